// File: rtl/mu0_control.sv
// mu0_control: fetch/execute control state machine for the MU0 16-bit processor.
// It drives the datapath mux selects, the register load enables, the ALU function
// code and the memory request strobes. These are decoded from the state and, in
// EXECUTE, from the opcode F and the accumulator flags N/Z.
// Optional feature macro: MU0_WAIT_EN adds the mem_rdy handshake. A memory
// access that is not ready holds the state and suppresses every register enable.
module mu0_control (
    input  logic       clk,
    input  logic       rst_n,
`ifdef MU0_WAIT_EN
    input  logic       mem_rdy,
`endif
    input  logic [3:0] F,
    input  logic       N,
    input  logic       Z,
    output logic       Addr_sel,
    output logic       X_sel,
    output logic       Y_sel,
    output logic [1:0] ALU_fs,
    output logic       PC_En,
    output logic       IR_En,
    output logic       ACC_En,
    output logic       MEMrq,
    output logic       RnW,
    output logic       Halted
);

    typedef enum logic [1:0] {
        INIT    = 2'b00,
        FETCH   = 2'b01,
        EXECUTE = 2'b10,
        HALT    = 2'b11
    } state_t;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] FS_Y   = 2'b00;
    localparam logic [1:0] FS_ADD = 2'b01;
    localparam logic [1:0] FS_INC = 2'b10;
    localparam logic [1:0] FS_SUB = 2'b11;

    state_t state;
    logic   stall;
    logic   jump_taken;
    logic   pc_en_raw;
    logic   ir_en_raw;
    logic   acc_en_raw;

    assign jump_taken = (F == OP_JMP) ||
                        ((F == OP_JGE) && !N) ||
                        ((F == OP_JNE) && !Z);

    // Decode the control word from state and opcode; enables are gated by stall later
    always_comb begin
        Addr_sel   = 1'b0;
        X_sel      = 1'b0;
        Y_sel      = 1'b0;
        ALU_fs     = FS_Y;
        MEMrq      = 1'b0;
        RnW        = 1'b0;
        pc_en_raw  = 1'b0;
        ir_en_raw  = 1'b0;
        acc_en_raw = 1'b0;
        case (state)
            FETCH: begin
                Addr_sel  = 1'b0;
                MEMrq     = 1'b1;
                RnW       = 1'b1;
                ir_en_raw = 1'b1;
                X_sel     = 1'b1;
                ALU_fs    = FS_INC;
                pc_en_raw = 1'b1;
            end
            EXECUTE: begin
                case (F)
                    OP_LDA: begin
                        Addr_sel   = 1'b1;
                        MEMrq      = 1'b1;
                        RnW        = 1'b1;
                        Y_sel      = 1'b0;
                        ALU_fs     = FS_Y;
                        acc_en_raw = 1'b1;
                    end
                    OP_STA: begin
                        Addr_sel = 1'b1;
                        MEMrq    = 1'b1;
                        RnW      = 1'b0;
                        X_sel    = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        Addr_sel   = 1'b1;
                        MEMrq      = 1'b1;
                        RnW        = 1'b1;
                        X_sel      = 1'b0;
                        Y_sel      = 1'b0;
                        ALU_fs     = (F == OP_ADD) ? FS_ADD : FS_SUB;
                        acc_en_raw = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        if (jump_taken) begin
                            Y_sel     = 1'b1;
                            ALU_fs    = FS_Y;
                            pc_en_raw = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            default: begin
            end
        endcase
    end

`ifdef MU0_WAIT_EN
    assign stall = MEMrq & ~mem_rdy;
`else
    assign stall = 1'b0;
`endif

    assign PC_En  = pc_en_raw  & ~stall;
    assign IR_En  = ir_en_raw  & ~stall;
    assign ACC_En = acc_en_raw & ~stall;

    // Sequence INIT -> FETCH <-> EXECUTE -> HALT; Halted latches on the edge into HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= INIT;
            Halted <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (!stall) begin
                        state <= EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (!stall) begin
                        if (F == OP_STP) begin
                            state  <= HALT;
                            Halted <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// tb_mu0_control: self-checking bench for mu0_control.
// A behavioural model tracks the instruction phase and predicts every output.
// The model is compared on each falling clock edge. Directed literal checks pin
// the key points: reset, fetch, each opcode class, halt, and asynchronous reset.
// The MU0_WAIT_EN macro enables the wait-state stimulus and connects mem_rdy.
module tb_mu0_control;

    logic       clk;
    logic       rst_n;
    logic       memRdy;
    logic [3:0] F;
    logic       N;
    logic       Z;
    logic       Addr_sel;
    logic       X_sel;
    logic       Y_sel;
    logic [1:0] ALU_fs;
    logic       PC_En;
    logic       IR_En;
    logic       ACC_En;
    logic       MEMrq;
    logic       RnW;
    logic       Halted;

    int tests;
    int errors;

    typedef enum int {P_INIT, P_FETCH, P_EXEC, P_HALT} phase_t;

    typedef struct packed {
        logic       addrSel;
        logic       xSel;
        logic       ySel;
        logic [1:0] aluFs;
        logic       pcEn;
        logic       irEn;
        logic       accEn;
        logic       memRq;
        logic       rnw;
    } ctrl_t;

    phase_t mPhase = P_INIT;
    bit     mHalted = 1'b0;
    ctrl_t  expCtrl;
    ctrl_t  actCtrl;

    mu0_control dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef MU0_WAIT_EN
        .mem_rdy  (memRdy),
`endif
        .F        (F),
        .N        (N),
        .Z        (Z),
        .Addr_sel (Addr_sel),
        .X_sel    (X_sel),
        .Y_sel    (Y_sel),
        .ALU_fs   (ALU_fs),
        .PC_En    (PC_En),
        .IR_En    (IR_En),
        .ACC_En   (ACC_En),
        .MEMrq    (MEMrq),
        .RnW      (RnW),
        .Halted   (Halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word from the instruction-level description of each phase
    function automatic ctrl_t modelOutputs(phase_t p, logic [3:0] f, logic n, logic z, logic rdy);
        ctrl_t c;
        bit taken;
        c = '0;
        if (p == P_FETCH) begin
            c.memRq = 1'b1;
            c.rnw   = 1'b1;
            c.irEn  = 1'b1;
            c.xSel  = 1'b1;
            c.aluFs = 2'b10;
            c.pcEn  = 1'b1;
        end else if (p == P_EXEC) begin
            taken = (f == 4'd4) || (f == 4'd5 && !n) || (f == 4'd6 && !z);
            if (f == 4'd0 || f == 4'd2 || f == 4'd3) begin
                c.addrSel = 1'b1;
                c.memRq   = 1'b1;
                c.rnw     = 1'b1;
                c.accEn   = 1'b1;
                c.aluFs   = (f == 4'd0) ? 2'b00 : ((f == 4'd2) ? 2'b01 : 2'b11);
            end else if (f == 4'd1) begin
                c.addrSel = 1'b1;
                c.memRq   = 1'b1;
            end else if (taken) begin
                c.ySel = 1'b1;
                c.pcEn = 1'b1;
            end
        end
        if (c.memRq && !rdy) begin
            c.pcEn  = 1'b0;
            c.irEn  = 1'b0;
            c.accEn = 1'b0;
        end
        return c;
    endfunction

    function automatic logic effRdy();
`ifdef MU0_WAIT_EN
        return memRdy;
`else
        return 1'b1;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        tests++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    // Model advances phase on each edge; reset returns it to INIT at once
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase  = P_INIT;
            mHalted = 1'b0;
        end else begin
            case (mPhase)
                P_INIT:  mPhase = P_FETCH;
                P_FETCH: if (!modelOutputs(mPhase, F, N, Z, effRdy()).memRq || effRdy()) mPhase = P_EXEC;
                P_EXEC: begin
                    if (!modelOutputs(mPhase, F, N, Z, effRdy()).memRq || effRdy()) begin
                        if (F == 4'd7) begin
                            mPhase  = P_HALT;
                            mHalted = 1'b1;
                        end else begin
                            mPhase = P_FETCH;
                        end
                    end
                end
                default: mPhase = P_HALT;
            endcase
        end
    end

    // Compare every output against the model each falling edge
    always @(negedge clk) begin
        expCtrl = modelOutputs(mPhase, F, N, Z, effRdy());
        actCtrl = '{addrSel: Addr_sel, xSel: X_sel, ySel: Y_sel, aluFs: ALU_fs,
                    pcEn: PC_En, irEn: IR_En, accEn: ACC_En, memRq: MEMrq, rnw: RnW};
        checkOutput("cycleCtrl", 16'(actCtrl), 16'(expCtrl));
        checkOutput("cycleHalted", 16'(Halted), 16'(mHalted));
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    // Set the opcode/flags during FETCH and advance into its EXECUTE cycle
    task automatic applyStimulus(input logic [3:0] f, input logic n, input logic z);
        F = f;
        N = n;
        Z = z;
        stepClock();
    endtask

    initial begin
        tests  = 0;
        errors = 0;
        rst_n  = 1'b0;
        memRdy = 1'b1;
        F      = 4'd0;
        N      = 1'b0;
        Z      = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetHalted", 16'(Halted), 16'd0);
        checkOutput("resetMemrq", 16'(MEMrq), 16'd0);
        checkOutput("resetPcEn", 16'(PC_En), 16'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("initIrEn", 16'(IR_En), 16'd0);
        checkOutput("initAluFs", 16'(ALU_fs), 16'd0);
        stepClock();
        checkOutput("fetchMemrq", 16'(MEMrq), 16'd1);
        checkOutput("fetchRnw", 16'(RnW), 16'd1);
        checkOutput("fetchIrEn", 16'(IR_En), 16'd1);
        checkOutput("fetchPcEn", 16'(PC_En), 16'd1);
        checkOutput("fetchAluFs", 16'(ALU_fs), 16'b10);

        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("ldaAddrSel", 16'(Addr_sel), 16'd1);
        checkOutput("ldaAccEn", 16'(ACC_En), 16'd1);
        checkOutput("ldaAluFs", 16'(ALU_fs), 16'b00);
        stepClock();
        applyStimulus(4'h2, 1'b0, 1'b0);
        checkOutput("addAccEn", 16'(ACC_En), 16'd1);
        checkOutput("addAluFs", 16'(ALU_fs), 16'b01);
        stepClock();
        applyStimulus(4'h3, 1'b1, 1'b0);
        checkOutput("subAluFs", 16'(ALU_fs), 16'b11);
        stepClock();
        applyStimulus(4'h1, 1'b0, 1'b1);
        checkOutput("staRnw", 16'(RnW), 16'd0);
        checkOutput("staAccEn", 16'(ACC_En), 16'd0);
        checkOutput("staMemrq", 16'(MEMrq), 16'd1);
        stepClock();

        applyStimulus(4'h5, 1'b1, 1'b0);
        checkOutput("jgeNegPcEn", 16'(PC_En), 16'd0);
        stepClock();
        applyStimulus(4'h5, 1'b0, 1'b0);
        checkOutput("jgePosPcEn", 16'(PC_En), 16'd1);
        checkOutput("jgePosYSel", 16'(Y_sel), 16'd1);
        stepClock();
        applyStimulus(4'h6, 1'b0, 1'b1);
        checkOutput("jneZeroPcEn", 16'(PC_En), 16'd0);
        stepClock();
        applyStimulus(4'h6, 1'b0, 1'b0);
        checkOutput("jneNzPcEn", 16'(PC_En), 16'd1);
        stepClock();
        applyStimulus(4'h4, 1'b1, 1'b1);
        checkOutput("jmpPcEn", 16'(PC_En), 16'd1);
        checkOutput("jmpMemrq", 16'(MEMrq), 16'd0);
        stepClock();

        applyStimulus(4'hB, 1'b0, 1'b0);
        checkOutput("nopPcEn", 16'(PC_En), 16'd0);
        checkOutput("nopMemrq", 16'(MEMrq), 16'd0);
        stepClock();
        checkOutput("afterNopIrEn", 16'(IR_En), 16'd1);

        applyStimulus(4'h0, 1'b0, 1'b0);
        checkOutput("preResetAccEn", 16'(ACC_En), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("asyncRstAccEn", 16'(ACC_En), 16'd0);
        checkOutput("asyncRstMemrq", 16'(MEMrq), 16'd0);
        stepClock();
        rst_n = 1'b1;
        #1;
        checkOutput("reinitIrEn", 16'(IR_En), 16'd0);
        stepClock();
        checkOutput("refetchIrEn", 16'(IR_En), 16'd1);

        applyStimulus(4'h7, 1'b0, 1'b0);
        checkOutput("stpHaltedLow", 16'(Halted), 16'd0);
        checkOutput("stpPcEn", 16'(PC_En), 16'd0);
        stepClock();
        checkOutput("haltHalted", 16'(Halted), 16'd1);
        F = 4'h0;
        repeat (10) stepClock();
        checkOutput("haltIdleMemrq", 16'(MEMrq), 16'd0);
        checkOutput("haltIdleIrEn", 16'(IR_En), 16'd0);
        checkOutput("haltStill", 16'(Halted), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("haltRstHalted", 16'(Halted), 16'd0);
        #1;
        rst_n = 1'b1;
        stepClock();
        checkOutput("postHaltFetch", 16'(IR_En), 16'd1);

`ifdef MU0_WAIT_EN
        memRdy = 1'b0;
        #1;
        checkOutput("waitIrEn", 16'(IR_En), 16'd0);
        checkOutput("waitPcEn", 16'(PC_En), 16'd0);
        checkOutput("waitMemrq", 16'(MEMrq), 16'd1);
        repeat (3) stepClock();
        checkOutput("waitHeldMemrq", 16'(MEMrq), 16'd1);
        checkOutput("waitHeldAluFs", 16'(ALU_fs), 16'b10);
        checkOutput("waitHeldIrEn", 16'(IR_En), 16'd0);
        memRdy = 1'b1;
        #1;
        checkOutput("readyIrEn", 16'(IR_En), 16'd1);
        applyStimulus(4'h2, 1'b0, 1'b0);
        checkOutput("readyExecAluFs", 16'(ALU_fs), 16'b01);
        checkOutput("readyExecAccEn", 16'(ACC_En), 16'd1);
        stepClock();
`endif

        stepClock();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
